mem_sram_controller: RTL and testbench

- Memory-side responder for the load/store requests issued by the execute stage: it consumes MEM_R_EN, MEM_W_EN, the ALU result (byte address) and the forwarded Rm value (store data).
- Services each request against an external 16-bit-wide SRAM as two half-word accesses.
- Returns ready to the pipeline hazard/freeze logic, and Read_Data to the write-back path.
- Sits in the MEM stage between the EXE/MEM pipeline register and the SRAM pins.

---
 rtl/mem_sram_controller_if.sv | 36 +++
 rtl/mem_sram_controller.sv | 189 ++++++++++++++++++
 tb/tb_mem_sram_controller.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sram_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sram_controller_if
//  Description : Pipeline-side load/store bundle between the EXE/MEM register
//                and the MEM-stage SRAM controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_sram_controller_if;
    logic        MEM_R_EN;   // load request
    logic        MEM_W_EN;   // store request
    logic [31:0] ALU_Res;    // byte address
    logic [31:0] VAL_RM;     // store data
    logic        ready;      // MEM stage may advance
    logic [31:0] Read_Data;  // load result

    // Pipeline side issues requests and consumes ready/result.
    modport master (
        output MEM_R_EN,
        output MEM_W_EN,
        output ALU_Res,
        output VAL_RM,
        input  ready,
        input  Read_Data
    );

    // Controller side services requests.
    modport slave (
        input  MEM_R_EN,
        input  MEM_W_EN,
        input  ALU_Res,
        input  VAL_RM,
        output ready,
        output Read_Data
    );
endinterface
`default_nettype wire

// File: rtl/mem_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sram_controller
//  Description : MEM-stage responder that services 32-bit loads/stores
//                against a 16-bit external SRAM as two half-word phases
//                (low then high), each lasting WAIT_CYCLES+1 clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 18
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    mem_sram_controller_if.slave       bus,
    output logic [SRAM_AW-1:0]         SRAM_ADDR,
    inout  wire  [15:0]                SRAM_DQ,
    output logic                       SRAM_WE_N,
    output logic                       SRAM_OE_N
);

    localparam logic [31:0] c_base_addr = 32'(BASE_ADDR);
    localparam logic [2:0]  c_last_cnt  = 3'(WAIT_CYCLES);
    localparam int          c_word_aw   = SRAM_AW - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2:0]             r_cnt;
    logic [2:0]             w_cnt_nxt;

    // Request captured at acceptance; the pipeline inputs are ignored after.
    logic [c_word_aw-1:0]   r_word_addr;
    logic [31:0]            r_wdata;
    logic                   r_write;

    logic [15:0]            r_rdata_lo;
    logic [31:0]            r_read_data;

    logic                   w_req;
    logic [31:0]            w_offset;
    logic                   w_phase_end;
    logic                   w_capture;
    logic                   w_sample_lo;
    logic                   w_sample_hi;
    logic                   w_dq_oe;
    logic [15:0]            w_dq_out;

    // A simultaneous load and store enable is treated as a store.
    assign w_req       = bus.MEM_R_EN | bus.MEM_W_EN;
    assign w_offset    = bus.ALU_Res - c_base_addr;
    assign w_phase_end = (r_cnt == c_last_cnt);

    // Offset bits outside the half-word address range are intentionally dropped.
    generate
        if (SRAM_AW < 31) begin : g_unused_offset_hi
            logic w_unused_offset_hi;
            assign w_unused_offset_hi = ^w_offset[31:SRAM_AW+1];
        end
    endgenerate
    logic w_unused_offset_lo;
    assign w_unused_offset_lo = ^w_offset[1:0];

    // State register: reset aborts any access at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: each half-word phase holds for WAIT_CYCLES+1 clocks.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_sample_lo = 1'b0;
        w_sample_hi = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = 3'd0;
                    w_capture   = 1'b1;
                end
            end
            S_LO: begin
                if (w_phase_end) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = 3'd0;
                    w_sample_lo = !r_write;
                end else begin
                    w_cnt_nxt   = r_cnt + 3'd1;
                end
            end
            S_HI: begin
                if (w_phase_end) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 3'd0;
                    w_sample_hi = !r_write;
                end else begin
                    w_cnt_nxt   = r_cnt + 3'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Request capture and read-data assembly; Read_Data changes only when a
    // load finishes its high phase, so it is stable while DONE shows ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_addr <= '0;
            r_wdata     <= 32'd0;
            r_write     <= 1'b0;
            r_rdata_lo  <= 16'd0;
            r_read_data <= 32'd0;
        end else begin
            if (w_capture) begin
                r_word_addr <= w_offset[SRAM_AW:2];
                r_wdata     <= bus.VAL_RM;
                r_write     <= bus.MEM_W_EN;
            end
            if (w_sample_lo) begin
                r_rdata_lo  <= SRAM_DQ;
            end
            if (w_sample_hi) begin
                r_read_data <= {SRAM_DQ, r_rdata_lo};
            end
        end
    end

    // SRAM pin decode from state only, so an async reset idles the pins instantly.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        w_dq_oe   = 1'b0;
        w_dq_out  = 16'd0;
        case (r_state)
            S_LO: begin
                SRAM_ADDR = {r_word_addr, 1'b0};
                w_dq_out  = r_wdata[15:0];
                if (r_write) begin
                    SRAM_WE_N = 1'b0;
                    w_dq_oe   = 1'b1;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            S_HI: begin
                SRAM_ADDR = {r_word_addr, 1'b1};
                w_dq_out  = r_wdata[31:16];
                if (r_write) begin
                    SRAM_WE_N = 1'b0;
                    w_dq_oe   = 1'b1;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign SRAM_DQ = w_dq_oe ? w_dq_out : 16'hzzzz;

    // ready is low in the accepting IDLE cycle and throughout the access.
    assign bus.ready     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
    assign bus.Read_Data = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_sram_controller
//  Description : Self-checking bench for mem_sram_controller with a
//                half-word SRAM pin model and a word-level reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sram_controller;

    localparam int BASE_ADDR   = 1024;
    localparam int WAIT_CYCLES = 1;
    localparam int SRAM_AW     = 18;
    localparam int PHASE       = WAIT_CYCLES + 1;

    logic                clk = 1'b0;
    logic                rst;
    wire  [15:0]         sram_dq;
    logic [SRAM_AW-1:0]  sram_addr;
    logic                sram_we_n;
    logic                sram_oe_n;

    mem_sram_controller_if bus();

    mem_sram_controller #(
        .BASE_ADDR   (BASE_ADDR),
        .WAIT_CYCLES (WAIT_CYCLES),
        .SRAM_AW     (SRAM_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq),
        .SRAM_WE_N (sram_we_n),
        .SRAM_OE_N (sram_oe_n)
    );

    always #5 clk = ~clk;

    // Weak pull-ups make a released bus read as 16'hFFFF.
    for (genvar gi = 0; gi < 16; gi++) begin : g_pullup
        pullup (sram_dq[gi]);
    end

    // Half-word SRAM pin model, indexed by the low 8 address bits.
    logic [15:0] sram_mem [0:255];
    logic        sram_drv;
    logic [15:0] sram_rd;
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [15:0] pre_val;

    assign sram_dq = sram_drv ? sram_rd : 16'hzzzz;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= 16'h0;
            sram_drv <= 1'b0;
            sram_rd  <= 16'h0;
        end else begin
            if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq;
            if (pre_en)     sram_mem[pre_addr]       <= pre_val;
            sram_drv <= !sram_oe_n;
            sram_rd  <= sram_mem[sram_addr[7:0]];
        end
    end

    // Word-level reference memory keyed by the SRAM word index.
    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] exp_rd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] word_key(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'(BASE_ADDR);
        return off[18:2];
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.MEM_R_EN = 1'b0;
            bus.MEM_W_EN = 1'b0;
            bus.ALU_Res  = $urandom;
            bus.VAL_RM   = $urandom;
            @(negedge clk);
            check_val("idle_ready", bus.ready, 1);
            check_val("idle_we_n", sram_we_n, 1);
            check_val("idle_oe_n", sram_oe_n, 1);
            check_val("idle_addr", sram_addr, 0);
            check_val("idle_dq", sram_dq, 16'hFFFF);
            check_val("idle_rdata", bus.Read_Data, exp_rd);
        end
    endtask

    // One complete access; keep holds a request high across DONE so the
    // next call starts in the cycle right after DONE.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic keep);
        logic [16:0] key;
        logic [17:0] lo_a;
        logic [17:0] hi_a;
        logic [31:0] word;
        logic [31:0] old_rd;
        logic        hi_phase;
        key    = word_key(addr);
        lo_a   = {key, 1'b0};
        hi_a   = {key, 1'b1};
        old_rd = exp_rd;
        if (wr) begin
            ref_mem[key] = data;
            word = data;
        end else begin
            word = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        end

        @(posedge clk); #1;
        bus.MEM_R_EN = rd;
        bus.MEM_W_EN = wr;
        bus.ALU_Res  = addr;
        bus.VAL_RM   = data;
        @(negedge clk);
        check_val("accept_ready", bus.ready, 0);
        check_val("accept_we_n", sram_we_n, 1);
        check_val("accept_oe_n", sram_oe_n, 1);
        check_val("accept_addr", sram_addr, 0);

        for (int k = 1; k <= 2 * PHASE; k++) begin
            @(posedge clk); #1;
            bus.MEM_R_EN = 1'($urandom);
            bus.MEM_W_EN = 1'($urandom);
            bus.ALU_Res  = $urandom;
            bus.VAL_RM   = $urandom;
            @(negedge clk);
            hi_phase = (k > PHASE);
            check_val("busy_ready", bus.ready, 0);
            check_val("busy_addr", sram_addr, hi_phase ? hi_a : lo_a);
            check_val("busy_rdata_hold", bus.Read_Data, old_rd);
            if (wr) begin
                check_val("wr_we_n", sram_we_n, 0);
                check_val("wr_oe_n", sram_oe_n, 1);
                check_val("wr_dq", sram_dq, hi_phase ? word[31:16] : word[15:0]);
            end else begin
                check_val("rd_we_n", sram_we_n, 1);
                check_val("rd_oe_n", sram_oe_n, 0);
            end
        end
        if (rd && !wr) exp_rd = word;

        @(posedge clk); #1;
        bus.MEM_R_EN = keep;
        bus.MEM_W_EN = 1'b0;
        bus.ALU_Res  = $urandom;
        @(negedge clk);
        check_val("done_ready", bus.ready, 1);
        check_val("done_we_n", sram_we_n, 1);
        check_val("done_oe_n", sram_oe_n, 1);
        check_val("done_addr", sram_addr, 0);
        check_val("done_rdata", bus.Read_Data, exp_rd);
        if (wr) check_val("done_dq", sram_dq, 16'hFFFF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst          = 1'b1;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        bus.ALU_Res  = 32'h0;
        bus.VAL_RM   = 32'h0;
        pre_en       = 1'b0;
        pre_addr     = 8'h0;
        pre_val      = 16'h0;
        exp_rd       = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready", bus.ready, 1);
        check_val("rst_rdata", bus.Read_Data, 0);
        check_val("rst_we_n", sram_we_n, 1);
        check_val("rst_oe_n", sram_oe_n, 1);
        check_val("rst_addr", sram_addr, 0);
        check_val("rst_dq", sram_dq, 16'hFFFF);
        rst = 1'b0;
        idle_cycles(2);

        // Load from preloaded SRAM: addr4=0x5678, addr5=0x1234
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = 8'd4; pre_val = 16'h5678;
        @(posedge clk); #1;
        pre_addr = 8'd5; pre_val = 16'h1234;
        @(posedge clk); #1;
        pre_en = 1'b0;
        ref_mem[word_key(32'd1032)] = 32'h1234_5678;
        run_txn(1'b1, 1'b0, 32'd1032, $urandom, 1'b0);
        check_val("load_value", bus.Read_Data, 32'h1234_5678);
        idle_cycles(1);

        // Store then back-to-back load to the same word
        run_txn(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 1'b1);
        run_txn(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        check_val("b2b_load_value", bus.Read_Data, 32'hDEAD_BEEF);
        idle_cycles(1);

        // Both enables act as a store; Read_Data untouched
        run_txn(1'b1, 1'b1, 32'd1024, 32'h0000_FFFF, 1'b0);
        check_val("both_en_rdata", bus.Read_Data, 32'hDEAD_BEEF);
        idle_cycles(1);

        // Randomized traffic, including wrap-around offsets and unaligned low bits
        for (int t = 0; t < 24; t++) begin
            int          kind;
            logic [31:0] a;
            logic        kp;
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0)
                a = 32'(BASE_ADDR) - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
            else
                a = 32'(BASE_ADDR) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            kp = 1'($urandom_range(0, 1));
            run_txn(kind != 1, kind != 0, a, $urandom, kp);
            if (!kp) idle_cycles(1);
        end

        // Make Read_Data non-zero before the reset test
        run_txn(1'b0, 1'b1, 32'd1040, 32'hA5A5_5A5A, 1'b1);
        run_txn(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
        check_val("pre_rst_rdata", bus.Read_Data, 32'hA5A5_5A5A);
        idle_cycles(1);

        // Reset asserted during the high phase of a store
        @(posedge clk); #1;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b1;
        bus.ALU_Res  = 32'd1044;
        bus.VAL_RM   = 32'h1357_9BDF;
        repeat (PHASE + 1) @(posedge clk);
        #2;
        check_val("hi_we_n_before_rst", sram_we_n, 0);
        check_val("hi_addr_before_rst", sram_addr, 18'd11);
        rst = 1'b1;
        #1;
        exp_rd = 32'h0;
        check_val("abort_we_n", sram_we_n, 1);
        check_val("abort_oe_n", sram_oe_n, 1);
        check_val("abort_dq", sram_dq, 16'hFFFF);
        check_val("abort_addr", sram_addr, 0);
        check_val("abort_ready_req", bus.ready, 0);
        check_val("abort_rdata", bus.Read_Data, 0);
        bus.MEM_W_EN = 1'b0;
        #1;
        check_val("abort_ready_noreq", bus.ready, 1);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
